// File: rtl/mux_stream_rr.sv
// rtl/mux_stream_rr.sv - INS:1 valid/ready stream mux with fixed or round-robin select
module mux_stream_rr #(
  parameter int INS   = 5,
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(INS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INS*WIDTH-1:0] in_data,
  input  logic [INS-1:0]       in_valid,
  output logic [INS-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SW-1:0]        s,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SW-1:0]        out_sel,
  input  logic                 out_ready
);

  logic             load;
  logic [INS-1:0]   grant;
  logic             found;
  int               j;
  logic             gany;
  logic [SW-1:0]    gidx;
  logic [WIDTH-1:0] gdata;
  logic [SW-1:0]    ptr;

  // One-hot grant: fixed select, or first valid channel starting at ptr with wraparound
  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    if (!mode) begin
      if (int'(s) < INS) grant[s] = in_valid[s];
    end else begin
      for (int i = 0; i < INS; i++) begin
        j = int'(ptr) + i;
        if (j >= INS) j = j - INS;
        if (!found && in_valid[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // Encode the granted channel's index and pick its data word
  always_comb begin
    gany  = |grant;
    gidx  = '0;
    gdata = '0;
    for (int k = 0; k < INS; k++) begin
      if (grant[k]) begin
        gidx  = SW'(k);
        gdata = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = ~out_valid | out_ready;
  assign in_ready = {INS{load}} & grant;

  // Output register stage and round-robin pointer; ptr moves past every served channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (gany) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_sel   <= gidx;
        ptr       <= (gidx == SW'(INS - 1)) ? '0 : gidx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_stream_rr.sv
// tb/tb_mux_stream_rr.sv - randomized and directed bench for mux_stream_rr
module tb_mux_stream_rr;

  localparam int INS   = 5;
  localparam int WIDTH = 8;
  localparam int SW    = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [INS*WIDTH-1:0] in_data;
  logic [INS-1:0]       in_valid;
  logic [INS-1:0]       in_ready;
  logic                 mode;
  logic [SW-1:0]        s;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic [SW-1:0]        out_sel;
  logic                 out_ready;

  logic [WIDTH-1:0]     chd [INS];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_ptr;

  mux_stream_rr #(.INS(INS), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .s         (s),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @* begin
    in_data = '0;
    for (int k = 0; k < INS; k++) in_data[k*WIDTH +: WIDTH] = chd[k];
  end

  function automatic int find_grant();
    if (mode == 1'b0) begin
      if (int'(s) < INS) begin
        if (in_valid[s]) return int'(s);
      end
      return -1;
    end
    for (int i = 0; i < INS; i++) begin
      int c;
      c = (m_ptr + i) % INS;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [INS-1:0] exp_ready();
    logic [INS-1:0] r;
    int g;
    r = '0;
    g = find_grant();
    if (g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // advance one clock and update the model with the transfer it implies
  task automatic tick();
    int   g;
    logic ld;
    g  = find_grant();
    ld = !m_valid || out_ready;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = chd[g];
        m_sel   = g;
        m_ptr   = (g + 1) % INS;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic hard_reset();
    in_valid = '0;
    rst_n    = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    mode = 1'b0; s = '0; out_ready = 1'b1;
    for (int k = 0; k < INS; k++) chd[k] = 8'hA0;
    hard_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (in_ready !== 5'b00000) begin bad++; $display("FAIL reset_in_ready got=%b want=00000", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0) begin
        bad++;
        $display("FAIL reset_out got v=%b d=%h s=%0d want v=0 d=00 s=0", out_valid, out_data, out_sel);
      end
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; s = 3'd3; in_valid = 5'b11111; out_ready = 1'b1;
    for (int k = 0; k < INS; k++) chd[k] = 8'(8'h10 + k);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (in_ready !== 5'b01000) begin bad++; $display("FAIL fixed_in_ready got=%b want=01000", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h13 || out_sel !== 3'd3) begin
        bad++;
        $display("FAIL fixed_out got v=%b d=%h s=%0d want v=1 d=13 s=3", out_valid, out_data, out_sel);
      end
    end
  endtask

  task automatic test_rr_all();
    hard_reset();
    mode = 1'b1; in_valid = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ($countones(in_ready) != 1 || in_ready !== exp_ready()) begin
        bad++; $display("FAIL rr_in_ready got=%b want=%b", in_ready, exp_ready());
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || int'(out_sel) != i % INS || out_data !== 8'(8'h10 + i % INS)) begin
        bad++;
        $display("FAIL rr_seq cycle=%0d got s=%0d d=%h want s=%0d d=%h", i, out_sel, out_data, i % INS, 8'(8'h10 + i % INS));
      end
    end
  endtask

  task automatic test_rr_backpressure();
    logic [WIDTH-1:0] hd;
    logic [SW-1:0]    hs;
    int               prev;
    int               nxt;
    mode = 1'b1; in_valid = 5'b10010; out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (in_ready !== exp_ready()) begin bad++; $display("FAIL bp_in_ready got=%b want=%b", in_ready, exp_ready()); end
      tick();
      total++;
      if (int'(out_sel) != m_sel || out_data !== m_data || int'(out_sel) == prev) begin
        bad++; $display("FAIL bp_alt got s=%0d want s=%0d prev=%0d", out_sel, m_sel, prev);
      end
      prev = int'(out_sel);
    end
    hd = out_data; hs = out_sel;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 5'b00000) begin bad++; $display("FAIL bp_stall_ready got=%b want=00000", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== hd || out_sel !== hs) begin
        bad++; $display("FAIL bp_frozen got v=%b d=%h s=%0d want v=1 d=%h s=%0d", out_valid, out_data, out_sel, hd, hs);
      end
    end
    out_ready = 1'b1;
    nxt = (hs == 3'd1) ? 4 : 1;
    #1;
    total++;
    if (in_ready !== 5'(1 << nxt)) begin bad++; $display("FAIL bp_release_ready got=%b want=%b", in_ready, 5'(1 << nxt)); end
    tick();
    total++;
    if (int'(out_sel) != nxt || out_valid !== 1'b1) begin bad++; $display("FAIL bp_release_sel got=%0d want=%0d", out_sel, nxt); end
  endtask

  task automatic test_out_of_range();
    mode = 1'b0; s = 3'd6; in_valid = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 5'b00000) begin bad++; $display("FAIL oor_in_ready got=%b want=00000", in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL oor_valid got=%b want=0", out_valid); end
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; in_valid = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin #1; tick(); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0) begin
      bad++; $display("FAIL async_reset got v=%b d=%h s=%0d want v=0 d=00 s=0", out_valid, out_data, out_sel);
    end
    model_reset();
    in_valid = 5'b01100;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 5'b00100) begin bad++; $display("FAIL async_first_ready got=%b want=00100", in_ready); end
    tick();
    total++;
    if (out_sel !== 3'd2 || out_valid !== 1'b1 || out_data !== chd[2]) begin
      bad++; $display("FAIL async_first_grant got s=%0d v=%b want s=2 v=1", out_sel, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < INS; k++) chd[k] = 8'($urandom);
      in_valid  = 5'($urandom);
      mode      = 1'($urandom_range(0, 1));
      s         = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      total++;
      if (in_ready !== exp_ready()) begin bad++; $display("FAIL rand_in_ready i=%0d got=%b want=%b", i, in_ready, exp_ready()); end
      tick();
      total++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || int'(out_sel) != m_sel))) begin
        bad++;
        $display("FAIL rand_out i=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d", i, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; mode = 1'b0; s = '0; out_ready = 1'b0;
    for (int k = 0; k < INS; k++) chd[k] = '0;
    model_reset();
    #12;
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_backpressure();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
